psram_qspi_responder: RTL and testbench

- Single-clock, synthesizable QSPI PSRAM device-side responder. It answers the pin-level traffic (sck, ce_n, d[3:0]) that our PSRAM controller produces for layer blocks such as the maxpool and conv engines.
- Backed by an on-chip byte memory. It stands in for the external PSRAM in integration sims and in the on-chip scratchpad configuration.
- Oversamples the bus with the system clock; supports quad fast read (0xEB) and quad write (0x38).

---
 rtl/psram_pkg.sv | 24 ++
 rtl/psram_qspi_responder_if.sv | 25 ++
 rtl/psram_pin_sync.sv | 47 ++++
 rtl/psram_qspi_responder.sv | 165 ++++++++++++++++
 tb/tb_psram_qspi_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_pkg.sv
`default_nettype none
// ============================================================================
// Package : psram_pkg
// Opcodes, FSM state encoding and bus framing constants for the PSRAM link.
// Rev     : 1.0
// ============================================================================
package psram_pkg;

   localparam logic [7:0] CMD_QREAD    = 8'hEB;
   localparam logic [7:0] CMD_QWRITE   = 8'h38;
   localparam int         ADDR_NIBBLES = 6;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      WAIT   = 3'd3,
      RDATA  = 3'd4,
      WDATA  = 3'd5,
      IGNORE = 3'd6
   } psram_state_t;

endpackage
`default_nettype wire

// File: rtl/psram_qspi_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : psram_qspi_responder_if
// QSPI PSRAM pin bundle; master is the controller, slave is the device.
// Rev       : 1.0
// ============================================================================
interface psram_qspi_responder_if;
   logic       psram_sck;
   logic       psram_ce_n;
   logic [3:0] psram_d_i;
   logic [3:0] psram_d_o;
   logic [3:0] psram_d_oe;
   logic       busy;

   modport master (
      output psram_sck, psram_ce_n, psram_d_i,
      input  psram_d_o, psram_d_oe, busy
   );

   modport slave (
      input  psram_sck, psram_ce_n, psram_d_i,
      output psram_d_o, psram_d_oe, busy
   );
endinterface
`default_nettype wire

// File: rtl/psram_pin_sync.sv
`default_nettype none
// ============================================================================
// Module : psram_pin_sync
// Two-flop synchronizers for sck/ce_n/d plus one-clk sck edge and ce_n fall pulses.
// Rev    : 1.0
// ============================================================================
module psram_pin_sync (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_sck,
   input  wire logic       i_ce_n,
   input  wire logic [3:0] i_d,
   output logic            o_sck_rise,
   output logic            o_sck_fall,
   output logic            o_ce_fall,
   output logic            o_ce_n,
   output logic [3:0]      o_d
);

   logic [2:0] r_sck;
   logic [2:0] r_ce;
   logic [3:0] r_d1;
   logic [3:0] r_d2;

   // ce_n history resets to "asserted" so leaving reset never fakes a falling edge
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sck <= 3'b000;
         r_ce  <= 3'b000;
         r_d1  <= 4'h0;
         r_d2  <= 4'h0;
      end else begin
         r_sck <= {r_sck[1:0], i_sck};
         r_ce  <= {r_ce[1:0], i_ce_n};
         r_d1  <= i_d;
         r_d2  <= r_d1;
      end
   end

   assign o_sck_rise = r_sck[1] & ~r_sck[2];
   assign o_sck_fall = ~r_sck[1] & r_sck[2];
   assign o_ce_fall  = ~r_ce[1] & r_ce[2];
   assign o_ce_n     = r_ce[1];
   assign o_d        = r_d2;

endmodule
`default_nettype wire

// File: rtl/psram_qspi_responder.sv
`default_nettype none
// ============================================================================
// Module : psram_qspi_responder
// QSPI PSRAM device model (0xEB quad read, 0x38 quad write) over an on-chip byte array.
// Rev    : 1.0
// ============================================================================
module psram_qspi_responder #(
   parameter int ADDR_WIDTH  = 24,
   parameter int MEM_BYTES   = 4096,
   parameter int WAIT_CYCLES = 6
) (
   input  wire logic             clk,
   input  wire logic             rst,
   psram_qspi_responder_if.slave bus
);
   import psram_pkg::*;

   localparam int c_mem_aw = ($clog2(MEM_BYTES) < ADDR_WIDTH) ? $clog2(MEM_BYTES) : ADDR_WIDTH;
   localparam logic [7:0]          c_wait_last = 8'(WAIT_CYCLES);
   localparam logic [7:0]          c_addr_last = 8'(ADDR_NIBBLES - 1);
   localparam logic [c_mem_aw-1:0] c_addr_one  = c_mem_aw'(1);

   logic       w_sck_rise;
   logic       w_sck_fall;
   logic       w_ce_fall;
   logic       w_ce_n;
   logic [3:0] w_d;

   psram_state_t        r_state;
   logic [7:0]          r_cnt;
   logic [7:0]          r_cmd;
   logic [c_mem_aw-1:0] r_addr;
   logic                r_hi;
   logic [3:0]          r_wnib;
   logic [7:0]          r_rd_data;
   logic [3:0]          r_d_o;
   logic [3:0]          r_d_oe;
   logic                r_busy;
   logic [7:0]          r_mem [MEM_BYTES];

   logic [7:0]          w_cmd_next;
   logic [c_mem_aw-1:0] w_addr_next;
   logic                w_we;

   psram_pin_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .i_sck      (bus.psram_sck),
      .i_ce_n     (bus.psram_ce_n),
      .i_d        (bus.psram_d_i),
      .o_sck_rise (w_sck_rise),
      .o_sck_fall (w_sck_fall),
      .o_ce_fall  (w_ce_fall),
      .o_ce_n     (w_ce_n),
      .o_d        (w_d)
   );

   assign w_cmd_next  = {r_cmd[6:0], w_d[0]};
   assign w_addr_next = {r_addr[c_mem_aw-5:0], w_d};
   assign w_we        = rst && !w_ce_n && (r_state == WDATA) && w_sck_rise && !r_hi;

   // Read port follows r_addr every cycle, so the next byte is ready well before its sck_fall
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[r_addr] <= {r_wnib, w_d};
      end
      r_rd_data <= r_mem[r_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_cmd   <= 8'd0;
         r_addr  <= '0;
         r_hi    <= 1'b1;
         r_wnib  <= 4'h0;
         r_d_o   <= 4'h0;
         r_d_oe  <= 4'h0;
         r_busy  <= 1'b0;
      end else if (w_ce_n) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_hi    <= 1'b1;
         r_d_o   <= 4'h0;
         r_d_oe  <= 4'h0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_ce_fall) begin
                  r_state <= CMD;
                  r_cnt   <= 8'd0;
                  r_busy  <= 1'b1;
               end
            end
            CMD: begin
               if (w_sck_rise) begin
                  r_cmd <= w_cmd_next;
                  r_cnt <= r_cnt + 8'd1;
                  if (r_cnt == 8'd7) begin
                     r_cnt   <= 8'd0;
                     r_state <= (w_cmd_next == CMD_QREAD || w_cmd_next == CMD_QWRITE) ? ADDR : IGNORE;
                  end
               end
            end
            ADDR: begin
               if (w_sck_rise) begin
                  r_addr <= w_addr_next;
                  r_cnt  <= r_cnt + 8'd1;
                  if (r_cnt == c_addr_last) begin
                     r_cnt   <= 8'd0;
                     r_hi    <= 1'b1;
                     r_state <= (r_cmd == CMD_QREAD) ? WAIT : WDATA;
                  end
               end
            end
            WAIT: begin
               if (w_sck_rise) begin
                  if (r_cnt != c_wait_last) begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end else if (w_sck_fall && r_cnt == c_wait_last) begin
                  r_state <= RDATA;
                  r_d_oe  <= 4'hF;
                  r_d_o   <= r_rd_data[7:4];
                  r_hi    <= 1'b0;
               end
            end
            RDATA: begin
               if (w_sck_fall) begin
                  if (r_hi) begin
                     r_d_o <= r_rd_data[7:4];
                     r_hi  <= 1'b0;
                  end else begin
                     r_d_o  <= r_rd_data[3:0];
                     r_hi   <= 1'b1;
                     r_addr <= r_addr + c_addr_one;
                  end
               end
            end
            WDATA: begin
               if (w_sck_rise) begin
                  if (r_hi) begin
                     r_wnib <= w_d;
                     r_hi   <= 1'b0;
                  end else begin
                     r_hi   <= 1'b1;
                     r_addr <= r_addr + c_addr_one;
                  end
               end
            end
            default: begin
               r_d_oe <= 4'h0;
            end
         endcase
      end
   end

   assign bus.psram_d_o  = r_d_o;
   assign bus.psram_d_oe = r_d_oe;
   assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_psram_qspi_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_psram_qspi_responder
// Scoreboard bench: bus-level controller tasks, byte-array reference model, sck-edge monitor.
// Rev    : 1.0
// ============================================================================
module tb_psram_qspi_responder;

   localparam int MEM_BYTES   = 4096;
   localparam int WAIT_CYCLES = 6;
   localparam int HALF        = 50;

   typedef struct {
      logic [3:0] nib;
      bit         known;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   psram_qspi_responder_if bus ();

   psram_qspi_responder #(
      .ADDR_WIDTH  (24),
      .MEM_BYTES   (MEM_BYTES),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] model [MEM_BYTES];
   bit         known [MEM_BYTES];
   exp_t       expq [$];
   logic [3:0] wq [$];
   int         checks = 0;
   int         errors = 0;
   bit         exp_rd = 1'b0;
   bit         exp_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Controller samples read data on sck rising edges; that is where the device is judged
   always @(posedge bus.psram_sck) begin
      exp_t e;
      if (!bus.psram_ce_n) begin
         chk("busy_in_tx", 32'(bus.busy), 32'(exp_busy));
         if (exp_rd) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_underflow: read nibble with empty expectation queue at %0t", $time);
            end else begin
               e = expq.pop_front();
               chk("rd_oe", 32'(bus.psram_d_oe), 32'hF);
               if (e.known) chk("rd_nibble", 32'(bus.psram_d_o), 32'(e.nib));
            end
         end else begin
            chk("oe_not_reading", 32'(bus.psram_d_oe), 32'h0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic sck_cycle(input logic [3:0] nib);
      bus.psram_d_i = nib;
      #HALF;
      bus.psram_sck = 1'b1;
      #HALF;
      bus.psram_sck = 1'b0;
   endtask

   task automatic tx_start();
      bus.psram_ce_n = 1'b0;
      exp_busy = 1'b1;
      #HALF;
   endtask

   task automatic tx_stop(input int gap);
      bus.psram_ce_n = 1'b1;
      exp_rd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("stop_busy", 32'(bus.busy), 32'h0);
      chk("stop_oe", 32'(bus.psram_d_oe), 32'h0);
      #gap;
   endtask

   task automatic send_cmd(input logic [7:0] op);
      logic [2:0] junk;
      for (int i = 7; i >= 0; i--) begin
         junk = 3'($urandom);
         sck_cycle({junk, op[i]});
      end
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4]);
   endtask

   task automatic push_byte(input logic [7:0] b);
      wq.push_back(b[7:4]);
      wq.push_back(b[3:0]);
   endtask

   task automatic write_tx(input logic [23:0] addr, input int gap);
      int a;
      a = int'(addr) % MEM_BYTES;
      tx_start();
      send_cmd(8'h38);
      send_addr(addr);
      for (int i = 0; i < wq.size(); i++) begin
         sck_cycle(wq[i]);
         if (i % 2 == 1) begin
            model[a] = {wq[i-1], wq[i]};
            known[a] = 1'b1;
            a = (a + 1) % MEM_BYTES;
         end
      end
      tx_stop(gap);
   endtask

   task automatic read_tx(input logic [23:0] addr, input int nbytes, input int abort, input int gap);
      int a;
      exp_t e;
      tx_start();
      send_cmd(8'hEB);
      send_addr(addr);
      repeat (WAIT_CYCLES) sck_cycle(4'($urandom));
      a = int'(addr) % MEM_BYTES;
      for (int b = 0; b < nbytes; b++) begin
         e.known = known[a];
         e.nib = model[a][7:4];
         expq.push_back(e);
         e.nib = model[a][3:0];
         expq.push_back(e);
         a = (a + 1) % MEM_BYTES;
      end
      exp_rd = 1'b1;
      for (int i = 0; i < 2 * nbytes; i++) begin
         if (i == abort) begin
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            chk("rst_oe", 32'(bus.psram_d_oe), 32'h0);
            chk("rst_d_o", 32'(bus.psram_d_o), 32'h0);
            chk("rst_busy", 32'(bus.busy), 32'h0);
            rst = 1'b1;
            exp_rd = 1'b0;
            exp_busy = 1'b0;
            expq.delete();
            break;
         end
         sck_cycle(4'($urandom));
      end
      tx_stop(gap);
   endtask

   initial begin
      logic [23:0] ad;
      int          n;
      bus.psram_sck  = 1'b0;
      bus.psram_ce_n = 1'b1;
      bus.psram_d_i  = 4'h0;
      #3;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_oe", 32'(bus.psram_d_oe), 32'h0);
      chk("reset_d_o", 32'(bus.psram_d_o), 32'h0);
      chk("reset_busy", 32'(bus.busy), 32'h0);
      rst = 1'b1;
      #(4 * HALF);

      // Write then read DE AD BE EF at 0x10
      wq.delete();
      push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
      write_tx(24'h000010, 4 * HALF);
      read_tx(24'h000010, 4, -1, 4 * HALF);

      // Address wrap at the top of memory, high address bits ignored
      wq.delete();
      push_byte(8'h11); push_byte(8'h22);
      write_tx(24'hABCFFF, 4 * HALF);
      read_tx(24'h000FFF, 2, -1, 4 * HALF);
      read_tx(24'h000000, 1, -1, 4 * HALF);

      // Unknown opcode carrying a write-shaped payload must not touch memory
      tx_start();
      send_cmd(8'h9F);
      send_addr(24'h000010);
      sck_cycle(4'h0);
      sck_cycle(4'h0);
      tx_stop(4 * HALF);
      read_tx(24'h000010, 4, -1, 4 * HALF);

      // Partial write: third nibble is dropped when ce_n rises
      wq.delete();
      push_byte(8'h00); push_byte(8'h55);
      write_tx(24'h000020, 4 * HALF);
      wq.delete();
      wq.push_back(4'hA); wq.push_back(4'hB); wq.push_back(4'hC);
      write_tx(24'h000020, 4 * HALF);
      read_tx(24'h000020, 2, -1, 4 * HALF);

      // Reset in the middle of a read burst, then a fresh read
      read_tx(24'h000010, 4, 3, 4 * HALF);
      read_tx(24'h000010, 4, -1, 4 * HALF);

      // Back-to-back reads with a one-sck-period gap
      read_tx(24'h000010, 4, -1, 2 * HALF);
      read_tx(24'h000FFF, 2, -1, 4 * HALF);

      // Randomized write/read pairs
      for (int t = 0; t < 12; t++) begin
         ad = 24'($urandom);
         n  = $urandom_range(1, 6);
         wq.delete();
         for (int k = 0; k < n; k++) push_byte(8'($urandom));
         write_tx(ad, 2 * HALF);
         read_tx(ad, n, -1, 2 * HALF);
      end
      read_tx(24'($urandom), 6, -1, 2 * HALF);

      chk("queue_drained", 32'(expq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
